sram_bus_responder: RTL and testbench
=====================================

# sram_bus_responder

Bus-side responder for the CPU bus that serves CPU reads and writes from external asynchronous 8-bit SRAM, replacing the block-RAM stand-in for main memory. It sits on sys_clk between the CPU bus (address, rd_req level, wr_en pulse, ready) and the SRAM pins. It inserts a programmable number of wait states and throttles the CPU through ready for the whole access.

## Interface
Parameters:
- WAIT_CYCLES, default 6, number of sys_clk cycles the SRAM strobe (oe_n or we_n) is held low; legal range 1..15.
- ADDR_W, default 16, SRAM address width.

Ports (clock and reset first):
- sys_clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of sys_clk.
- cs  input  1  address decode for this block, qualified with each request.
- bus_addr  input  ADDR_W  CPU address.
- bus_rd_req  input  1  CPU read request, a level signal; a new read is its rising edge.
- bus_wr_en  input  1  CPU write strobe, one-cycle pulse.
- bus_wr_data  input  8  CPU write data.
- bus_rd_data  output  8  read data, held until the next read completes.
- bus_ready  output  1  high when idle; low while an access is in progress.
- overrun  output  1  sticky flag, set when a write arrives while the block is busy.
- sram_addr  output  ADDR_W  SRAM address.
- sram_dq_out  output  8  SRAM write data.
- sram_dq_oe  output  1  drive enable for the top-level tristate on the DQ pins.
- sram_dq_in  input  8  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active low.

## Operation
- Request detection:
  - rd_rise = bus_rd_req & ~rd_req_d, where rd_req_d is a registered copy of bus_rd_req.
  - A request is accepted only when cs is high on the same edge.
- States: IDLE, READ, WRITE, WREC.
- IDLE:
  - Accepted write: latch address and data; ce_n=0, we_n=0, dq_oe=1, ready=0; cnt=WAIT_CYCLES-1; go to WRITE.
  - Accepted read (no write on the same edge): latch address; ce_n=0, oe_n=0, ready=0; cnt=WAIT_CYCLES-1; go to READ.
  - A write and a read on the same edge: the write wins and the read is recorded as pending.
- READ:
  - cnt≠0: decrement cnt.
  - cnt=0: bus_rd_data<=sram_dq_in; ce_n=1, oe_n=1, ready=1; go to IDLE.
- WRITE:
  - cnt≠0: decrement cnt.
  - cnt=0: we_n=1; keep ce_n low and keep driving the data; go to WREC.
- WREC: ce_n=1, dq_oe=0.
  - Pending read: start the read exactly as from IDLE; ready stays 0.
  - Otherwise: ready=1; go to IDLE.
- Read arriving while busy: an accepted rd_rise outside IDLE sets pending. It is served as soon as the current access ends, without returning ready high in between.
- Write arriving while busy: an accepted wr_en outside IDLE is dropped and sets overrun.
- oe_n and we_n are never low at the same time.
- dq_oe is never high while oe_n is low.

## Timing
- Reset values:
  - bus_ready=1, bus_rd_data=0, overrun=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
  - sram_addr=0, sram_dq_out=0, pending=0, state IDLE.
- Reset mid-access: all strobes go inactive and dq_oe=0 on the reset edge. The access is abandoned and bus_rd_data is not updated.
- All outputs are registered; none is driven combinationally from an input.
- Read, with the accepting edge at k:
  - ready is low for edges k..k+WAIT_CYCLES-1.
  - oe_n is low for exactly WAIT_CYCLES cycles.
  - sram_dq_in is sampled at edge k+WAIT_CYCLES; bus_rd_data is valid and ready=1 after that edge.
- Write, with the accepting edge at k:
  - we_n is low for WAIT_CYCLES cycles.
  - Address and data are held one extra cycle after we_n rises (WREC).
  - ready returns high after edge k+WAIT_CYCLES+1.
- Back-to-back: a read pending behind a write starts at the WREC edge; the total busy time is (WAIT_CYCLES+1)+WAIT_CYCLES cycles.
- No cycles are spent in IDLE between accesses that the CPU issues once ready is high.

## Test plan
All scenarios use WAIT_CYCLES=3.
- Reset check: hold reset_n low 4 cycles -> ready=1, all strobes 1, dq_oe=0, overrun=0, bus_rd_data=0x00.
- Read: SRAM model holds 0xA5 at 0x1234; raise bus_rd_req with cs=1 and addr 0x1234 -> oe_n low 3 cycles, ready low 3 cycles, then rd_data=0xA5 and ready=1.
- Write then read back: write 0x5A to 0x8001 -> we_n low 3 cycles, dq_oe high 4 cycles, ready low 4 cycles; a following read of 0x8001 returns 0x5A.
- Write and read on the same edge: raise rd_req together with wr_en (addr 0x0010, data 0x77) -> write completes first, read starts at WREC, ready stays low 7 cycles, rd_data=0x77.
- Overrun and cs gating: pulse wr_en during a read -> overrun=1 and the SRAM contents are unchanged; rd_req rising with cs=0 -> no strobes, ready stays 1.
- Reset mid-access: assert reset_n low at the second cycle of a read -> strobes inactive next edge, ready=1, rd_data keeps its previous value.

Source files
------------

// File: rtl/sram_bus_responder.sv
// CPU bus responder for asynchronous 8-bit SRAM: wait-stated read/write strobes,
// bus_ready throttling, a queued read behind a busy access and a sticky overrun flag.
module sram_bus_responder #(
    parameter int WAIT_CYCLES = 6,
    parameter int ADDR_W      = 16
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rd_req,
    input  logic              bus_wr_en,
    input  logic [7:0]        bus_wr_data,
    output logic [7:0]        bus_rd_data,
    output logic              bus_ready,
    output logic              overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WREC} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_req_prev_q, rd_req_prev_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dq_out_q, dq_out_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              ready_q, ready_d;
    logic              overrun_q, overrun_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;

    logic              rd_acc, wr_acc, pend_now, start_rd;
    logic [ADDR_W-1:0] pend_addr_now, rd_addr;

    assign rd_acc        = cs & bus_rd_req & ~rd_req_prev_q;
    assign wr_acc        = cs & bus_wr_en;
    assign pend_now      = pending_q | rd_acc;
    assign pend_addr_now = rd_acc ? bus_addr : pend_addr_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_req_prev_d = bus_rd_req;
        pending_d     = pending_q;
        pend_addr_d   = pend_addr_q;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        rd_data_d     = rd_data_q;
        ready_d       = ready_q;
        overrun_d     = overrun_q;
        ce_n_d        = ce_n_q;
        oe_n_d        = oe_n_q;
        we_n_d        = we_n_q;
        dq_oe_d       = dq_oe_q;
        start_rd      = 1'b0;
        rd_addr       = pend_addr_now;

        if (state_q != IDLE) begin
            if (wr_acc) overrun_d = 1'b1;
            if (rd_acc) begin
                pending_d   = 1'b1;
                pend_addr_d = bus_addr;
            end
        end

        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    // A read on the same edge is queued behind the write.
                    addr_d      = bus_addr;
                    dq_out_d    = bus_wr_data;
                    ce_n_d      = 1'b0;
                    we_n_d      = 1'b0;
                    dq_oe_d     = 1'b1;
                    ready_d     = 1'b0;
                    cnt_d       = CNT_INIT;
                    state_d     = WRITE;
                    pending_d   = rd_acc;
                    pend_addr_d = bus_addr;
                end else if (pend_now) begin
                    start_rd = 1'b1;
                end
            end
            READ: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_data_d = sram_dq_in;
                    if (pend_now) begin
                        start_rd = 1'b1;
                    end else begin
                        ce_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    we_n_d  = 1'b1;
                    state_d = WREC;
                end
            end
            WREC: begin
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                if (pend_now) begin
                    start_rd = 1'b1;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_rd) begin
            addr_d    = rd_addr;
            ce_n_d    = 1'b0;
            oe_n_d    = 1'b0;
            ready_d   = 1'b0;
            cnt_d     = CNT_INIT;
            pending_d = 1'b0;
            state_d   = READ;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            rd_req_prev_q <= 1'b0;
            pending_q     <= 1'b0;
            pend_addr_q   <= '0;
            addr_q        <= '0;
            dq_out_q      <= 8'h00;
            ready_q       <= 1'b1;
            overrun_q     <= 1'b0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            dq_oe_q       <= 1'b0;
            // An abandoned access leaves the last read data visible.
            if (state_q == IDLE) rd_data_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_req_prev_q <= rd_req_prev_d;
            pending_q     <= pending_d;
            pend_addr_q   <= pend_addr_d;
            addr_q        <= addr_d;
            dq_out_q      <= dq_out_d;
            rd_data_q     <= rd_data_d;
            ready_q       <= ready_d;
            overrun_q     <= overrun_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            we_n_q        <= we_n_d;
            dq_oe_q       <= dq_oe_d;
        end
    end

    assign bus_rd_data = rd_data_q;
    assign bus_ready   = ready_q;
    assign overrun     = overrun_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder with WAIT_CYCLES=3 against a behavioural async SRAM;
// read data is predicted into exp_q when a read is issued and popped when ready returns.
module tb_sram_bus_responder;

  localparam int W = 3;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic [15:0] bus_addr = '0;
  logic        bus_rd_req = 1'b0;
  logic        bus_wr_en = 1'b0;
  logic [7:0]  bus_wr_data = '0;
  logic [7:0]  bus_rd_data;
  logic        bus_ready;
  logic        overrun;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_in;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  logic        model_en = 1'b0;
  logic [7:0]  exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rl, ol, wl, dl;

  sram_bus_responder #(.WAIT_CYCLES(W), .ADDR_W(16)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .cs(cs), .bus_addr(bus_addr),
    .bus_rd_req(bus_rd_req), .bus_wr_en(bus_wr_en), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_ready(bus_ready), .overrun(overrun),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // asynchronous SRAM model
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;
  always @(posedge sram_we_n) begin
    if (model_en && !sram_ce_n && sram_dq_oe) mem[sram_addr] = sram_dq_out;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // strobe invariants, every cycle once out of reset
  always @(negedge sys_clk) begin
    if (model_en && reset_n) begin
      chk("oe_we_excl", {15'd0, !sram_oe_n && !sram_we_n}, 16'd0);
      chk("dqoe_vs_oe", {15'd0, sram_dq_oe && !sram_oe_n}, 16'd0);
    end
  end

  // counts the busy window starting at the negedge after the accepting edge
  task automatic wait_ready();
    int n;
    rl = 0; ol = 0; wl = 0; dl = 0; n = 0;
    while (!bus_ready && n < 60) begin
      rl++;
      if (!sram_oe_n) ol++;
      if (!sram_we_n) wl++;
      if (sram_dq_oe) dl++;
      n++;
      @(negedge sys_clk);
    end
    if (n >= 60) chk("ready_timeout", 16'd0, 16'd1);
  endtask

  task automatic start_read(input logic [15:0] a);
    @(negedge sys_clk);
    cs = 1'b1; bus_addr = a; bus_rd_req = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {8'd0, bus_rd_data}, {8'd0, e});
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] d, input string tag);
    exp_q.push_back(d);
    start_read(a);
    wait_ready();
    bus_rd_req = 1'b0;
    chk({tag, "_rdy_low"}, 16'(rl), 16'(W));
    chk({tag, "_oe_low"}, 16'(ol), 16'(W));
    pop_check({tag, "_data"});
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input string tag);
    @(negedge sys_clk);
    cs = 1'b1; bus_addr = a; bus_wr_data = d; bus_wr_en = 1'b1;
    @(negedge sys_clk);
    bus_wr_en = 1'b0;
    wait_ready();
    chk({tag, "_rdy_low"}, 16'(rl), 16'(W + 1));
    chk({tag, "_we_low"}, 16'(wl), 16'(W));
    chk({tag, "_dqoe_hi"}, 16'(dl), 16'(W + 1));
    chk({tag, "_mem"}, {8'd0, mem[a]}, {8'd0, d});
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;

    // reset check
    repeat (4) @(negedge sys_clk);
    chk("rst_ready", {15'd0, bus_ready}, 16'd1);
    chk("rst_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'd7);
    chk("rst_dq_oe", {15'd0, sram_dq_oe}, 16'd0);
    chk("rst_overrun", {15'd0, overrun}, 16'd0);
    chk("rst_rd_data", {8'd0, bus_rd_data}, 16'd0);
    chk("rst_addr", sram_addr, 16'd0);
    chk("rst_dq_out", {8'd0, sram_dq_out}, 16'd0);
    reset_n = 1'b1;
    model_en = 1'b1;

    do_read(16'h1234, 8'hA5, "read1");
    do_write(16'h8001, 8'h5A, "write1");
    do_read(16'h8001, 8'h5A, "readback");

    // write and read on the same edge
    exp_q.push_back(8'h77);
    @(negedge sys_clk);
    cs = 1'b1; bus_addr = 16'h0010; bus_wr_data = 8'h77; bus_wr_en = 1'b1; bus_rd_req = 1'b1;
    @(negedge sys_clk);
    bus_wr_en = 1'b0;
    wait_ready();
    bus_rd_req = 1'b0;
    chk("wr_rd_rdy_low", 16'(rl), 16'(2 * W + 1));
    chk("wr_rd_we_low", 16'(wl), 16'(W));
    chk("wr_rd_oe_low", 16'(ol), 16'(W));
    chk("wr_rd_mem", {8'd0, mem[16'h0010]}, 16'h0077);
    pop_check("wr_rd_data");

    // write while a read is busy is dropped
    exp_q.push_back(8'hA5);
    start_read(16'h1234);
    bus_wr_data = 8'hFF; bus_wr_en = 1'b1;
    @(negedge sys_clk);
    bus_wr_en = 1'b0;
    wait_ready();
    bus_rd_req = 1'b0;
    pop_check("ovr_rd_data");
    chk("ovr_flag", {15'd0, overrun}, 16'd1);
    chk("ovr_mem", {8'd0, mem[16'h1234]}, 16'h00A5);

    // rd_req rising with cs low is ignored
    @(negedge sys_clk);
    cs = 1'b0; bus_rd_req = 1'b1;
    repeat (4) begin
      @(negedge sys_clk);
      chk("cs0_ready", {15'd0, bus_ready}, 16'd1);
      chk("cs0_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'd7);
    end
    bus_rd_req = 1'b0;
    cs = 1'b1;

    // reset in the second cycle of a read
    start_read(16'h0010);
    reset_n = 1'b0; bus_rd_req = 1'b0;
    @(negedge sys_clk);
    chk("mrst_strobes", {13'd0, sram_ce_n, sram_oe_n, sram_we_n}, 16'd7);
    chk("mrst_dq_oe", {15'd0, sram_dq_oe}, 16'd0);
    chk("mrst_ready", {15'd0, bus_ready}, 16'd1);
    chk("mrst_rd_data", {8'd0, bus_rd_data}, 16'h00A5);
    chk("mrst_overrun", {15'd0, overrun}, 16'd0);
    reset_n = 1'b1;

    do_read(16'h0010, 8'h77, "post_rst");

    // random write/read-back pairs
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rd = 8'($urandom_range(0, 255));
      do_write(ra, rd, "rnd_wr");
      do_read(ra, rd, "rnd_rd");
    end

    chk("exp_q_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
